// File: rtl/uart_pkg.sv
// Shared types for the APB3 command master: FSM state encoding and the
// response record returned to the command requester.
package uart_pkg;

  typedef enum logic [1:0] {
    APB_MST_IDLE,
    APB_MST_SETUP,
    APB_MST_ACCESS,
    APB_MST_RESP
  } apb_mst_state_t;

  // Response data is carried at the widest legal bus width and narrowed at the port.
  localparam int APB_MST_MAX_DW = 32;

  typedef struct packed {
    logic [APB_MST_MAX_DW-1:0] rdata;
    logic                      slverr;
    logic                      timeout;
    logic                      misalign;
  } apb_mst_rsp_t;

  // A disabled timeout still needs a 1-bit counter to keep the declaration legal.
  function automatic int apb_mst_cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_apb_master.sv
// Single-outstanding APB3 initiator: command in, SETUP/ACCESS on the bus,
// read data and error status out on a held response channel.
module uart_apb_master
  import uart_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      i_apb_pclk,
  input  logic                      i_apb_presetn,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                      o_rsp_slverr,
  output logic                      o_rsp_timeout,
  output logic                      o_rsp_misalign,
  output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
  output logic                      o_apb_pwrite,
  output logic                      o_apb_psel,
  output logic                      o_apb_penable,
  input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
  input  logic                      i_apb_pready,
  input  logic                      i_apb_pslverr,
  output logic                      o_busy
);

  localparam int CNT_W = apb_mst_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '1;
  localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK =
    APB_ADDR_WIDTH'(APB_DATA_WIDTH / 8 - 1);

  apb_mst_state_t r_state;
  apb_mst_state_t w_state_next;
  logic [CNT_W-1:0] r_cnt;
  apb_mst_rsp_t     r_rsp;
  logic w_accept;
  logic w_misalign;
  logic w_timeout;

  assign w_accept   = (r_state == APB_MST_IDLE) && i_cmd_valid;
  assign w_misalign = |(i_cmd_addr & ALIGN_MASK);
  // PREADY in the terminal-count cycle takes priority over the abort.
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_state == APB_MST_ACCESS) &&
                      !i_apb_pready && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      APB_MST_IDLE:   if (i_cmd_valid) w_state_next = w_misalign ? APB_MST_RESP : APB_MST_SETUP;
      APB_MST_SETUP:  w_state_next = APB_MST_ACCESS;
      APB_MST_ACCESS: if (i_apb_pready || w_timeout) w_state_next = APB_MST_RESP;
      APB_MST_RESP:   if (i_rsp_ready) w_state_next = APB_MST_IDLE;
      default:        w_state_next = APB_MST_IDLE;
    endcase
  end

  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
    if (!i_apb_presetn) r_state <= APB_MST_IDLE;
    else                r_state <= w_state_next;
  end

  // Bus and response outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
    if (!i_apb_presetn) begin
      o_apb_psel    <= 1'b0;
      o_apb_penable <= 1'b0;
      o_apb_paddr   <= '0;
      o_apb_pwdata  <= '0;
      o_apb_pwrite  <= 1'b0;
      o_rsp_valid   <= 1'b0;
      r_cnt         <= '0;
      r_rsp         <= '0;
    end else begin
      o_apb_psel    <= (w_state_next == APB_MST_SETUP) || (w_state_next == APB_MST_ACCESS);
      o_apb_penable <= (w_state_next == APB_MST_ACCESS);
      o_rsp_valid   <= (w_state_next == APB_MST_RESP);

      if (w_accept && !w_misalign) begin
        o_apb_paddr  <= i_cmd_addr;
        o_apb_pwdata <= i_cmd_wdata;
        o_apb_pwrite <= i_cmd_write;
      end

      if (r_state != APB_MST_ACCESS) r_cnt <= '0;
      else if (!i_apb_pready && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;

      if (w_accept && w_misalign) begin
        r_rsp <= '{rdata: '0, slverr: 1'b1, timeout: 1'b0, misalign: 1'b1};
      end else if ((r_state == APB_MST_ACCESS) && i_apb_pready) begin
        r_rsp.rdata    <= o_apb_pwrite ? '0 : APB_MST_MAX_DW'(i_apb_prdata);
        r_rsp.slverr   <= i_apb_pslverr;
        r_rsp.timeout  <= 1'b0;
        r_rsp.misalign <= 1'b0;
      end else if (w_timeout) begin
        r_rsp <= '{rdata: '0, slverr: 1'b1, timeout: 1'b1, misalign: 1'b0};
      end else if ((r_state == APB_MST_RESP) && i_rsp_ready) begin
        r_rsp <= '0;
      end
    end
  end

  assign o_rsp_rdata    = r_rsp.rdata[APB_DATA_WIDTH-1:0];
  assign o_rsp_slverr   = r_rsp.slverr;
  assign o_rsp_timeout  = r_rsp.timeout;
  assign o_rsp_misalign = r_rsp.misalign;
  assign o_cmd_ready    = (r_state == APB_MST_IDLE);
  assign o_busy         = (r_state != APB_MST_IDLE);

endmodule
